alu_core: RTL and testbench



---
 rtl/alu_core.sv | 80 ++++++++
 tb/tb_alu_core.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered add/sub/AND/OR unit with carry, zero, negative and overflow flags.
// One operation per clock, result visible one cycle after the sampling edge.
module alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       alu_ctrl,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;
    logic             overflow_d, overflow_q;
    logic             valid_q;

    // Shared adder; alu_ctrl[0] both inverts b and supplies the +1 for subtract.
    // The OR path deliberately uses the inverted operand, so ctrl 11 yields a | ~b.
    always_comb begin
        bb            = alu_ctrl[0] ? ~b : b;
        {cout, sum}   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, alu_ctrl[0]};
        result_d      = sum;
        overflow_d    = 1'b0;
        unique case (alu_ctrl)
            2'b00, 2'b01: begin
                result_d   = sum;
                overflow_d = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10:   result_d = a & bb;
            2'b11:   result_d = a | bb;
            default: result_d = sum;
        endcase
        carry_d    = cout;
        zero_d     = (result_d == '0);
        negative_d = result_d[WIDTH-1];
    end

    // Output register: reset wins, idle cycles hold data and drop out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core (WIDTH = 8).
module tb_alu_core;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] alu_ctrl;
    logic       in_valid;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       out_valid;

    int n_applied = 0;
    int n_miscompares = 0;

    alu_core #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .in_valid  (in_valid),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] ctrl;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    localparam int NumVecs = 12;
    vec_t vecs[NumVecs];

    // Compare {result, carry, zero, negative, overflow, out_valid} against expectation.
    task automatic check(input string name, input logic [7:0] er, input logic ec,
                         input logic ez, input logic en, input logic ev, input logic eov);
        n_applied++;
        if ({result, carry_out, zero, negative, overflow, out_valid} !==
            {er, ec, ez, en, ev, eov}) begin
            n_miscompares++;
            $display("FAIL %s: got res=%h c=%b z=%b n=%b v=%b ov=%b, want res=%h c=%b z=%b n=%b v=%b ov=%b",
                     name, result, carry_out, zero, negative, overflow, out_valid,
                     er, ec, ez, en, ev, eov);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 ns after the next rising edge.
    task automatic drive(input logic rst, input logic vld, input logic [7:0] ta,
                         input logic [7:0] tb, input logic [1:0] tc);
        @(negedge clk);
        reset    = rst;
        in_valid = vld;
        a        = ta;
        b        = tb;
        alu_ctrl = tc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          a      b      ctrl   res    c     z     n     v
        vecs[0]  = '{8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'hBD, 8'hA5, 2'b00, 8'h62, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{8'hBD, 8'hA5, 2'b01, 8'h18, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'h80, 8'h01, 2'b01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'hBD, 8'hA5, 2'b10, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
        // a | ~b: 0xBD | 0x5A = 0xFF; adder 0xBD + 0x5A + 1 = 0x118
        vecs[6]  = '{8'hBD, 8'hA5, 2'b11, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 8'h0F, 2'b11, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'hF0, 8'h0F, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{8'h05, 8'h05, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b1;
        a        = '0;
        b        = '0;
        alu_ctrl = '0;

        // Reset held two cycles with random valid traffic.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom));
            check($sformatf("reset%0d", i), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Table of back-to-back valid operations.
        for (int i = 0; i < NumVecs; i++) begin
            drive(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].ctrl);
            check($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z,
                  vecs[i].n, vecs[i].v, 1'b1);
        end

        // in_valid toggling: idle cycles hold data and drop out_valid.
        drive(1'b0, 1'b1, 8'h12, 8'h34, 2'b00);
        check("tog_op0", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'hFF, 8'hFF, 2'b01);
        check("tog_idle0", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h80, 8'h80, 2'b00);
        check("tog_op1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h01, 8'h02, 2'b11);
        check("tog_idle1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h7F, 8'h7F, 2'b10);
        check("tog_idle2", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the same cycle as a valid op drops the op.
        drive(1'b0, 1'b1, 8'hBD, 8'hA5, 2'b00);
        check("mid_pre", 8'h62, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 8'h00, 8'h01, 2'b01);
        check("mid_reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'hAA, 8'h55, 2'b11);
        check("mid_post_idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 8'h01, 2'b01);
        check("mid_resume", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
